fetch_unit: RTL

- Instruction-fetch stage of the RV32 pipeline: owns the PC and issues word requests to instruction memory.
- Buffers returned instructions with their PCs in a small in-order queue and presents {pc, inst} to the IF/ID stage with a valid/ready handshake.
- Handles EX-stage redirects (taken branch/jump) by re-steering the PC and discarding stale in-flight responses.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_queue.sv | 79 +++++++
 rtl/fetch_unit.sv | 88 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage and its in-order queue.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RV32_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            filled;
  } fetch_slot_t;

  // Pointer width for a power-of-two queue depth; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order circular buffer: slots are reserved with a PC at request time, filled with
// the instruction when it returns, and popped from the head; flush empties it in one cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int QDEPTH = 2,
  localparam int PW     = ptr_width(QDEPTH),
  localparam int CW     = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              reserve,
  input  logic [XLEN-1:0]   reserve_pc,
  input  logic              fill,
  input  logic [XLEN-1:0]   fill_inst,
  input  logic              pop,
  output fetch_slot_t       head,
  output logic [CW-1:0]     reserved,
  output logic [CW-1:0]     live_out
);

  fetch_slot_t       slots [QDEPTH];
  logic [PW-1:0]     head_ptr;
  logic [PW-1:0]     tail_ptr;
  logic [PW-1:0]     fill_ptr;

  // Pointers wrap naturally because QDEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      fill_ptr <= '0;
      reserved <= '0;
      live_out <= '0;
    end else if (flush) begin
      head_ptr <= tail_ptr;
      fill_ptr <= tail_ptr;
      reserved <= '0;
      live_out <= '0;
    end else begin
      if (reserve) tail_ptr <= tail_ptr + 1'b1;
      if (fill)    fill_ptr <= fill_ptr + 1'b1;
      if (pop)     head_ptr <= head_ptr + 1'b1;
      reserved <= reserved + CW'(reserve) - CW'(pop);
      live_out <= live_out + CW'(reserve) - CW'(fill);
    end
  end

  // The fill slot is always reserved and the tail slot always free, so they never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QDEPTH; i++) slots[i] <= '0;
    end else if (!flush) begin
      if (reserve) begin
        slots[tail_ptr].pc     <= reserve_pc;
        slots[tail_ptr].inst   <= '0;
        slots[tail_ptr].filled <= 1'b0;
      end
      if (fill) begin
        slots[fill_ptr].inst   <= fill_inst;
        slots[fill_ptr].filled <= 1'b1;
      end
    end
  end

  assign head = slots[head_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    (reserve && !flush) |-> (reserved < CW'(QDEPTH) || pop))
    else $error("fetch_queue: reserve while full");
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    (pop && !flush) |-> (reserved != '0))
    else $error("fetch_queue: pop while empty");
  a_fill_has_slot: assert property (@(posedge clk) disable iff (!rst)
    (fill && !flush) |-> (live_out != '0))
    else $error("fetch_queue: fill with no unfilled slot");

endmodule

// File: rtl/fetch_unit.sv
// RV32 instruction-fetch stage: owns the PC, issues imem word requests, queues returned
// instructions in order and re-steers on EX redirects while dropping stale responses.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int              QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [XLEN-1:0]   imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_inst
);

  localparam int CW = ptr_width(QDEPTH) + 1;

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   reserved;
  logic [CW-1:0]   live_out;
  logic [CW:0]     inflight;
  fetch_slot_t     head;
  logic            req_fire;
  logic            q_reserve;
  logic            q_fill;
  logic            q_pop;
  logic            unused_pc_lsbs;

  // Every request still owed a response, live or stale, counts against the queue depth.
  assign inflight       = {1'b0, live_out} + {1'b0, drop_cnt};
  assign imem_req_valid = rst && (reserved < CW'(QDEPTH)) && (inflight < (CW + 1)'(QDEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign out_valid = (reserved != '0) && head.filled;
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;

  // A redirect overrides all queue bookkeeping for the cycle; the flush wins.
  assign q_reserve = req_fire && !redirect_valid;
  assign q_fill    = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign q_pop     = out_valid && out_ready && !redirect_valid;

  assign unused_pc_lsbs = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      pc       <= {redirect_pc[XLEN-1:2], 2'b00};
      drop_cnt <= CW'(inflight + (CW + 1)'(req_fire) - (CW + 1)'(imem_rsp_valid));
    end else begin
      if (req_fire) pc <= pc + 32'd4;
      if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
    end
  end

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .reserve    (q_reserve),
    .reserve_pc (pc),
    .fill       (q_fill),
    .fill_inst  (imem_rsp_data),
    .pop        (q_pop),
    .head       (head),
    .reserved   (reserved),
    .live_out   (live_out)
  );

  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> ((live_out != '0) || (drop_cnt != '0)))
    else $error("fetch_unit: imem response with no request outstanding");

endmodule
